// File: rtl/aes128_package.sv
// Shared types, constants and helpers for the AES-128 datapath blocks.
package aes128_package;

  typedef bit [7:0]   bv8_t;
  typedef bit [127:0] bv128_t;

  localparam int unsigned AES128_BLOCK_BYTES = 16;
  localparam int unsigned AES128_BLOCK_BITS  = 128;
  localparam int unsigned SHARES_MIN         = 2;
  localparam int unsigned SHARES_MAX         = 5;

  // Supported masking orders for the masked core.
  function automatic bit shares_legal(input int unsigned n);
    return (n >= SHARES_MIN) && (n <= SHARES_MAX);
  endfunction

  // Byte k of a block, byte 0 being the most significant.
  function automatic bv8_t aes_get_byte(input bv128_t d, input logic [3:0] k);
    return d[{~k, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/aes128_byte_serializer.sv
// Holds one 128-bit block (loaded or XOR-folded in) and streams it out
// MSB byte first over valid/ready, clearing itself on the last handshake.
module aes128_byte_serializer
  import aes128_package::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         i_load,
  input  logic         i_fold,
  input  logic [127:0] i_data,
  input  logic         i_valid_nxt,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [7:0]   o_byte,
  output logic         o_last
);

  localparam int unsigned K_W = $clog2(AES128_BLOCK_BYTES);
  localparam logic [K_W-1:0] K_LAST = K_W'(AES128_BLOCK_BYTES - 1);

  logic [127:0]   r_data;
  logic [K_W-1:0] r_k;
  logic           r_valid;
  logic [7:0]     r_byte;
  logic           r_last;

  logic [127:0]   w_data_nxt;
  logic [K_W-1:0] w_k_nxt;
  logic           w_hs;
  logic           w_last_hs;

  // Next block contents and byte index; outputs are registered from these.
  always_comb begin
    w_hs       = r_valid & i_ready;
    w_last_hs  = w_hs & r_last;
    w_data_nxt = r_data;
    w_k_nxt    = r_k;
    if (i_load) begin
      w_data_nxt = i_data;
      w_k_nxt    = '0;
    end else if (i_fold) begin
      w_data_nxt = r_data ^ i_data;
    end else if (w_last_hs) begin
      w_data_nxt = '0;
      w_k_nxt    = '0;
    end else if (w_hs) begin
      w_k_nxt = r_k + K_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_data  <= '0;
      r_k     <= '0;
      r_valid <= 1'b0;
      r_byte  <= '0;
      r_last  <= 1'b0;
    end else begin
      r_data  <= w_data_nxt;
      r_k     <= w_k_nxt;
      r_valid <= i_valid_nxt;
      r_byte  <= i_valid_nxt ? 8'(aes_get_byte(w_data_nxt, w_k_nxt)) : 8'h00;
      r_last  <= i_valid_nxt && (w_k_nxt == K_LAST);
    end
  end

  assign o_valid = r_valid;
  assign o_byte  = r_byte;
  assign o_last  = r_last;

endmodule

// File: rtl/aes128_unmask_serializer.sv
// Unmasks a Boolean-shared AES-128 ciphertext by registered XOR folding,
// one share per cycle, then streams it out as 16 bytes and zeroizes.
module aes128_unmask_serializer
  import aes128_package::*;
#(
  parameter int unsigned NUM_SHARES = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [NUM_SHARES*128-1:0]   in_shares_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [7:0]                  out_byte_o,
  output logic                        out_last_o,
  output logic                        busy_o
);

  if (!shares_legal(NUM_SHARES)) begin : g_bad_shares
    $error("aes128_unmask_serializer: NUM_SHARES must be in 2..5");
  end

  localparam int unsigned CNT_W = $clog2(NUM_SHARES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_SHARES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FOLD = 2'd1,
    S_EMIT = 2'd2
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [127:0]     r_share [1:NUM_SHARES-1];
  logic [CNT_W-1:0] r_cnt;
  logic             r_in_ready;
  logic             r_busy;

  logic             w_capture;
  logic             w_fold;
  logic             w_fold_last;
  logic [127:0]     w_fold_data;
  logic [127:0]     w_ser_data;

  // Next-state and fold control; share 0 goes straight to the accumulator.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_fold      = 1'b0;
    w_fold_last = 1'b0;
    w_fold_data = '0;
    for (int s = 1; s < int'(NUM_SHARES); s++) begin
      if (r_cnt == CNT_W'(s)) w_fold_data = r_share[s];
    end
    case (r_state)
      S_IDLE: begin
        if (in_valid_i && r_in_ready) begin
          w_capture   = 1'b1;
          w_state_nxt = S_FOLD;
        end
      end
      S_FOLD: begin
        w_fold = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_fold_last = 1'b1;
          w_state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_valid_o && out_ready_i && out_last_o) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Share registers are wiped as soon as they have been folded in.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_in_ready <= 1'b1;
      r_busy     <= 1'b0;
      for (int s = 1; s < int'(NUM_SHARES); s++) r_share[s] <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt == S_IDLE);
      r_busy     <= (w_state_nxt != S_IDLE);
      if (w_capture) begin
        for (int s = 1; s < int'(NUM_SHARES); s++) begin
          r_share[s] <= in_shares_i[128*s +: 128];
        end
        r_cnt <= CNT_W'(1);
      end else if (w_fold) begin
        for (int s = 1; s < int'(NUM_SHARES); s++) begin
          if (r_cnt == CNT_W'(s)) r_share[s] <= '0;
        end
        r_cnt <= w_fold_last ? '0 : r_cnt + CNT_W'(1);
      end
    end
  end

  assign w_ser_data = w_capture ? in_shares_i[127:0] : w_fold_data;

  aes128_byte_serializer u_ser (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_load      (w_capture),
    .i_fold      (w_fold),
    .i_data      (w_ser_data),
    .i_valid_nxt (w_state_nxt == S_EMIT),
    .i_ready     (out_ready_i),
    .o_valid     (out_valid_o),
    .o_byte      (out_byte_o),
    .o_last      (out_last_o)
  );

  assign in_ready_o = r_in_ready;
  assign busy_o     = r_busy;

endmodule

// File: doc/aes128_unmask_serializer.md
Name: aes128_unmask_serializer

Overview:
- Output end of the masked AES-128 datapath. The masked core produces a ciphertext as NUM_SHARES Boolean shares; this block is the decoder for that masking encoding.
- Captures all shares of one 128-bit block in a single handshake, then recombines them by registered XOR, one share per cycle.
- Emits the unmasked ciphertext as 16 bytes over a valid/ready stream, then zeroizes all internal state.

Parameters:
- NUM_SHARES, 2, number of Boolean shares per bit; legal values 2..5, elaboration error otherwise.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous active-high reset.
- in_valid_i  input  1  shared block available.
- in_ready_o  output  1  block accepted when in_valid_i && in_ready_o.
- in_shares_i  input  NUM_SHARES*128  share s occupies bits [128*s+127 : 128*s].
- out_valid_o  output  1  out_byte_o is valid.
- out_ready_i  input  1  byte consumed when out_valid_o && out_ready_i.
- out_byte_o  output  8  unmasked ciphertext byte.
- out_last_o  output  1  high with byte 15 of a block.
- busy_o  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, any time, including mid-block) returns to IDLE and sets:
  - share registers, accumulator, share counter and byte counter to 0;
  - in_ready_o=1, out_valid_o=0, out_byte_o=0, out_last_o=0, busy_o=0.
- State machine has three states: IDLE, FOLD, EMIT.
- IDLE:
  - in_ready_o=1.
  - On an input handshake: accumulator <= share 0, shares 1..N-1 are registered, share counter <= 1, next state FOLD.
- FOLD:
  - Each cycle: accumulator <= accumulator XOR share[counter]; that share register is zeroed in the same cycle; counter increments.
  - Exactly NUM_SHARES-1 cycles, then EMIT.
  - Shares are never XORed combinationally with each other before registration.
- EMIT:
  - out_valid_o=1.
  - out_byte_o = accumulator byte k, where byte 0 = bits [127:120] and byte 15 = bits [7:0].
  - On each output handshake, k increments.
  - out_byte_o and out_last_o are held stable while out_valid_o=1 && out_ready_i=0.
  - The handshake on k=15 (out_last_o=1) clears the accumulator and k to 0 and returns to IDLE.
- Latency:
  - Handshake at cycle t gives first out_valid_o at cycle t+NUM_SHARES.
  - With out_ready_i held at 1, the last byte is at t+NUM_SHARES+15 and in_ready_o is back at t+NUM_SHARES+16.
  - Throughput is one block per NUM_SHARES+16 cycles; no overlap of capture with emission.
- in_ready_o is 0 outside IDLE; in_valid_i and in_shares_i are ignored there.
- out_valid_o is 0 outside EMIT; out_byte_o is forced to 0 when out_valid_o=0, so no partial recombination is ever visible.
- Counter widths: share counter uses $clog2(NUM_SHARES)+1 bits and never wraps past NUM_SHARES-1; byte counter uses 4 bits and wraps 15->0 only on the final handshake.

Decomposition:
- Add to aes128_package:
  - typedef bv128_t (bit[127:0]);
  - constant AES128_BLOCK_BYTES = 16;
  - localparam-style legality check on NUM_SHARES, reusing the existing supported range 2..5.
- Reuse bv8_t for the byte path.
- One natural sub-module: aes128_byte_serializer (128-bit load, valid/ready byte output, last flag, clear on last handshake). The FSM and fold logic stay in the top.

Test Plan:
- Basic decode, NUM_SHARES=2:
  - Stimulus: C = 69c4e0d86a7b0430d8cdb78070b4c55a, share1 = a5 repeated 16 times, share0 = C XOR share1, out_ready_i=1.
  - Required response: bytes 69,c4,e0,...,5a in that order; first out_valid_o exactly 2 cycles after the input handshake; out_last_o only on 5a; in_ready_o high 18 cycles after the handshake.
- NUM_SHARES=5:
  - Stimulus: shares 0..3 random, share4 = C XOR shares 0..3.
  - Required response: same byte stream as the basic case; first valid 5 cycles after the handshake; out_byte_o=0 during all FOLD cycles.
- Backpressure:
  - Stimulus: out_ready_i toggles 1,0,0,1,... during EMIT.
  - Required response: out_byte_o and out_last_o stable while stalled; no byte dropped or duplicated; exactly 16 handshakes per block.
- Back-to-back blocks:
  - Stimulus: in_valid_i held high with two different blocks.
  - Required response: second block accepted only after byte 15 of the first; in_ready_o=0 throughout FOLD and EMIT.
- Reset mid-EMIT:
  - Stimulus: assert rst_i after byte 7 is consumed.
  - Required response: immediately out_valid_o=0, busy_o=0, in_ready_o=1; internal registers read 0; the next block decodes correctly starting from byte 0.
- Zeroization:
  - Stimulus: complete one block, then idle.
  - Required response: after the last handshake, accumulator and all share registers are 0 (checked by hierarchical probe); out_byte_o=0.
